// File: rtl/im_loader_if.sv
// im_loader_if: byte stream (valid/ready) plus IM write port; master = source/memory side, slave = loader
interface im_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  modport master(output rx_data, rx_valid, input rx_ready, im_we, im_addr, im_wdata);
  modport slave(input rx_data, rx_valid, output rx_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/im_loader.sv
// im_loader: boot loader writing a counted big-endian word image into IM; ports clk, reset, start, bus (stream in, IM write out), cpu_hold, done, error
module im_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  im_loader_if.slave  bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, LAST, DONE, ERR} state_t;
  localparam logic [31:0] CAP = 32'(1) << ADDR_WIDTH;
  state_t state, state_n;
  logic [15:0] count;
  logic [15:0] cnt_n;
  logic [ADDR_WIDTH:0] idx;
  logic [1:0] bidx;
  logic [31:0] word;
  logic acc, last;
  assign bus.rx_ready = state == HDR0 || state == HDR1 || state == DATA;
  assign cpu_hold = state != DONE;
  assign done = state == DONE;
  assign error = state == ERR;
  assign acc = bus.rx_valid && bus.rx_ready;
  assign cnt_n = {count[15:8], bus.rx_data};
  assign last = 32'(idx) + 32'd1 == 32'(count);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: state_n = start ? HDR0 : state;
      HDR0: state_n = acc ? HDR1 : HDR0;
      HDR1: state_n = !acc ? HDR1 : 32'(cnt_n) > CAP ? ERR : cnt_n == 16'd0 ? LAST : DATA;
      DATA: state_n = acc && bidx == 2'd3 && last ? LAST : DATA;
      LAST: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      idx <= '0;
      bidx <= '0;
      word <= '0;
      bus.im_we <= 1'b0;
      bus.im_addr <= BASE_ADDR;
      bus.im_wdata <= '0;
    end else begin
      bus.im_we <= 1'b0;
      if (acc)
        case (state)
          HDR0: count[15:8] <= bus.rx_data;
          HDR1: begin
            count[7:0] <= bus.rx_data;
            idx <= '0;
            bidx <= '0;
          end
          DATA: begin
            word <= {word[23:0], bus.rx_data};
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              bus.im_we <= 1'b1;
              bus.im_addr <= BASE_ADDR + (32'(idx) << 2);
              bus.im_wdata <= {word[23:0], bus.rx_data};
              idx <= idx + 1'b1;
            end
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: scoreboard bench for im_loader; expected IM writes are queued as words are streamed
module tb_im_loader;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic cpu_hold, done, error;
  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];
  logic [31:0] q[$];
  im_loader_if bus();
  im_loader dut(.clk(clk), .reset(reset), .start(start), .bus(bus), .cpu_hold(cpu_hold), .done(done), .error(error));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.im_we === 1'b1) begin
      if (sb.size() == 0) check("we_unexpected", 32'(bus.im_addr), 32'hFFFF_FFFF);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("addr", bus.im_addr, e[63:32]);
        check("data", bus.im_wdata, e[31:0]);
      end
    end
  task automatic put(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      bus.rx_valid = 0;
      bus.rx_data = 8'hxx;
      check("ready_gap", 32'(bus.rx_ready), 32'd1);
    end
    @(negedge clk);
    bus.rx_valid = 1;
    bus.rx_data = b;
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.rx_valid = 0;
  endtask
  task automatic pulse_start;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(error), 32'd0);
  endtask
  task automatic run_image(input int gap);
    logic [15:0] c;
    c = 16'(q.size());
    pulse_start();
    put(c[15:8], gap);
    put(c[7:0], gap);
    foreach (q[i]) begin
      logic [31:0] w;
      w = q[i];
      sb.push_back({32'h3000 + 32'(i) * 4, w});
      put(w[31:24], gap);
      put(w[23:16], gap);
      put(w[15:8], gap);
      put(w[7:0], gap);
    end
    @(negedge clk);
    check("k1_done", 32'(done), 32'd0);
    check("k1_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check("k2_done", 32'(done), 32'd1);
    check("k2_hold", 32'(cpu_hold), 32'd0);
    check("k2_ready", 32'(bus.rx_ready), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
  endtask
  task automatic check_reset_vals;
    check("rst_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_we", 32'(bus.im_we), 32'd0);
    check("rst_addr", bus.im_addr, 32'h3000);
    check("rst_wdata", bus.im_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
  endtask
  initial begin
    bus.rx_valid = 0;
    bus.rx_data = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check_reset_vals();
    q = {32'h24080005, 32'hAC080000};
    run_image(0);
    q = {};
    run_image(0);
    pulse_start();
    put(8'h10, 0);
    put(8'h01, 0);
    repeat (4) begin
      @(negedge clk);
      check("ovf_err", 32'(error), 32'd1);
      check("ovf_hold", 32'(cpu_hold), 32'd1);
      check("ovf_ready", 32'(bus.rx_ready), 32'd0);
    end
    q = {32'h11223344};
    run_image(0);
    q = {32'h24080005, 32'hAC080000};
    run_image(3);
    pulse_start();
    put(8'h00, 0);
    put(8'h02, 0);
    put(8'h55, 0);
    put(8'h66, 0);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check_reset_vals();
    q = {32'hCAFEF00D, 32'h01234567};
    run_image(1);
    q = {32'hDEADBEEF};
    run_image(0);
    q = {};
    for (int i = 0; i < 4096; i++) q.push_back(32'(i) * 32'h0001_0003 ^ 32'hA5A5_0000);
    run_image(0);
    check("full_last_addr", bus.im_addr, 32'h6FFC);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time writer for the instruction memory, i.e. the write side of the memory the fetch unit reads.
- Receives a byte stream (valid/ready) holding a 16-bit word count followed by big-endian 32-bit instruction words.
- Writes each word to IM at consecutive word addresses starting at the PC reset vector.
- Holds the CPU in reset via cpu_hold until the image is complete.

Parameters:
- ADDR_WIDTH, 12, IM word-address width; capacity = 2^ADDR_WIDTH words (4096).
- BASE_ADDR, 32'h0000_3000, byte address written by word 0; equals the PC reset vector.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin a load; sampled in IDLE, DONE, ERR only.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  one-cycle IM write strobe.
- im_addr  output  32  IM byte address, word-aligned.
- im_wdata  output  32  IM write data.
- cpu_hold  output  1  drives CPU reset; high = CPU held.
- done  output  1  image loaded.
- error  output  1  header count exceeds capacity.

Behaviour:
- Handshake: a byte is accepted on a posedge where rx_valid && rx_ready. There is no other consumption, and rx_data is ignored otherwise.
- States:
  - IDLE: rx_ready=0, cpu_hold=1. start -> HDR0.
  - HDR0: rx_ready=1. Accept byte -> count[15:8], go to HDR1.
  - HDR1: rx_ready=1. Accept byte -> count[7:0]. Then:
    - count > 2^ADDR_WIDTH -> ERR.
    - count == 0 -> LAST.
    - else -> DATA with word index=0, byte index=0.
  - DATA: rx_ready=1. Bytes are shifted in, first byte = bits [31:24].
    - On accepting byte index 3 of word i: the word register is complete.
    - im_we=1 in the following cycle, with im_addr = BASE_ADDR + 4*i and im_wdata = assembled word.
    - If i == count-1 -> LAST, else i increments and DATA continues.
    - Byte acceptance continues during the im_we cycle; no IM backpressure.
  - LAST: rx_ready=0, one cycle. This cycle carries the final im_we pulse (or none if count==0). -> DONE.
  - DONE: done=1, cpu_hold=0, rx_ready=0. start -> HDR0; in that same edge done drops and cpu_hold rises.
  - ERR: error=1, cpu_hold=1, rx_ready=0. start -> HDR0 and error clears.
- Timing: the last byte is accepted at edge k. im_we is high in cycle k+1. done=1 and cpu_hold=0 from cycle k+2. The CPU therefore never fetches in the same cycle as the final write.
- start outside IDLE/DONE/ERR is ignored.
- im_we is high for exactly one cycle per word, and never in IDLE/HDR0/HDR1/DONE/ERR.
- When im_we=0, im_addr and im_wdata hold their last values.
- Word index counter is ADDR_WIDTH+1 bits wide. No wrap is possible because count is bounded by the HDR1 check. count == 2^ADDR_WIDTH is legal and fills IM exactly.
- im_addr[1:0] is always 0.
- Reset values: state=IDLE, rx_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_hold=1, done=0, error=0. Counters and the partial word are cleared.
- Reset mid-load aborts immediately. The partial word is discarded, no further im_we is issued, and words already written remain in IM.
- rx_valid gaps of any length in any receiving state stall progress with no side effects.

Test Plan:
- Nominal load: reset, start, stream 00 02 24 08 00 05 AC 08 00 00.
  - im_we pulses twice: (0x3000, 0x24080005) then (0x3004, 0xAC080000).
  - done=1 and cpu_hold=0 exactly two cycles after the last byte is accepted.
- Empty image: stream 00 00 -> no im_we; LAST then DONE; done=1 two cycles after the second header byte.
- Overflow: stream 10 01 (4097 > 4096) -> ERR; error=1, cpu_hold=1, rx_ready=0, no im_we. A subsequent start with 00 01 + 4 bytes loads normally and error clears.
- Gapped valid: same image as the nominal load with rx_valid low for 3 cycles between every byte -> identical write sequence and data; rx_ready stays 1 throughout HDR0/HDR1/DATA.
- Reset mid-word: start, 00 02, then 2 data bytes, then reset -> im_we never asserts, all outputs return to reset values. A new start with a full image writes from 0x3000 with correctly assembled data (no stale bytes).
- Reload: after DONE, pulse start -> cpu_hold=1 and done=0 next cycle. Stream 00 01 DE AD BE EF -> write (0x3000, 0xDEADBEEF), then DONE again.
